// File: rtl/change_dispenser_pkg.sv
// Shared vending definitions: denomination codes, hopper strobe mapping and
// dispenser FSM state encodings.
package change_dispenser_pkg;

    localparam int NUM_COINS = 4;

    localparam logic [1:0] COIN_50   = 2'd0;
    localparam logic [1:0] COIN_100  = 2'd1;
    localparam logic [1:0] COIN_500  = 2'd2;
    localparam logic [1:0] COIN_1000 = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FIRE  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    typedef logic [3:0] pend_cnt_t;

    // Motor bit n drives the hopper for denomination code n.
    function automatic logic [3:0] motor_bit(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    // Largest denomination with pending work wins.
    function automatic logic [1:0] pick_coin(input logic [3:0] nz);
        if (nz[3])      return COIN_1000;
        else if (nz[2]) return COIN_500;
        else if (nz[1]) return COIN_100;
        else            return COIN_50;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_counter.sv
// Pending-coin counter for one denomination: 4-bit saturating up/down with
// synchronous clear. Simultaneous inc and dec cancel out.
module coin_counter
    import change_dispenser_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_clr,
    input  logic      i_inc,
    input  logic      i_dec,
    output pend_cnt_t o_count,
    output logic      o_sat
);

    pend_cnt_t r_count;
    logic      w_sat;

    assign w_sat   = (r_count == 4'd15);
    assign o_sat   = w_sat;
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            if (!w_sat) r_count <= r_count + 4'd1;
        end else if (i_dec && !i_inc) begin
            if (r_count != 4'd0) r_count <= r_count - 4'd1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin change dispenser: queues change requests per denomination and pays them
// out one coin at a time, largest first, with strobe/sense/timeout sequencing.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DROP50,
    input  logic       DROP100,
    input  logic       DROP500,
    input  logic       DROP1000,
    input  logic       Sense,
    input  logic       ClearFault,
    output logic [3:0] Motor,
    output logic [1:0] CoinOut,
    output logic       CoinDone,
    output logic       Busy,
    output logic       Fault,
    output logic       Overflow,
    output logic [2:0] o_dbg_state
);

    localparam int MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int MAX_T  = (MAX_PG > TIMEOUT_CYCLES) ? MAX_PG : TIMEOUT_CYCLES;
    localparam int TW     = (MAX_T < 2) ? 1 : $clog2(MAX_T + 1);

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_sel;
    logic [1:0]    r_coin_out;
    logic          r_overflow;

    logic [2:0]    w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [1:0]    w_sel_nxt;

    logic [3:0]    w_drop;
    logic [3:0]    w_dec;
    logic [3:0]    w_sat;
    logic [3:0]    w_nz;
    pend_cnt_t     w_cnt [NUM_COINS];
    logic          w_confirm;
    logic          w_clr;
    logic          w_lost;

    assign w_drop    = {DROP1000, DROP500, DROP100, DROP50};
    assign w_confirm = (r_state == ST_WAIT) && Sense;
    assign w_dec     = w_confirm ? motor_bit(r_sel) : 4'b0000;
    assign w_clr     = (r_state == ST_FAULT) && ClearFault;
    // A request is lost only when it cannot be absorbed; a same-cycle
    // confirmed coin of that denomination frees the slot.
    assign w_lost    = |(w_drop & w_sat & ~w_dec);

    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_cnt
        coin_counter u_cnt (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_clr   (w_clr),
            .i_inc   (w_drop[gi]),
            .i_dec   (w_dec[gi]),
            .o_count (w_cnt[gi]),
            .o_sat   (w_sat[gi])
        );
        assign w_nz[gi] = |w_cnt[gi];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (|w_nz) begin
                    w_sel_nxt   = pick_coin(w_nz);
                    w_state_nxt = ST_FIRE;
                    w_timer_nxt = '0;
                end
            end
            ST_FIRE: begin
                if (r_timer == TW'(PULSE_CYCLES - 1)) begin
                    w_state_nxt = ST_WAIT;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_WAIT: begin
                if (Sense) begin
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = '0;
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = ST_FAULT;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_timer == TW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_FAULT: begin
                if (ClearFault) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_sel      <= COIN_50;
            r_coin_out <= COIN_50;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_sel      <= w_sel_nxt;
            if (w_confirm) r_coin_out <= r_sel;
            r_overflow <= (r_overflow & ~ClearFault) | w_lost;
        end
    end

    // CoinDone is a valid-only strobe with no ready: the vending control unit
    // must take CoinOut in the cycle CoinDone is high.
    assign Motor       = (r_state == ST_FIRE) ? motor_bit(r_sel) : 4'b0000;
    assign CoinDone    = w_confirm;
    assign CoinOut     = w_confirm ? r_sel : r_coin_out;
    assign Fault       = (r_state == ST_FAULT);
    assign Busy        = (r_state != ST_IDLE) || (|w_nz);
    assign Overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hopper sensor model plus coin scoreboard.
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    logic       CLK;
    logic       RST;
    logic       DROP50, DROP100, DROP500, DROP1000;
    logic       Sense;
    logic       ClearFault;
    logic [3:0] Motor;
    logic [1:0] CoinOut;
    logic       CoinDone;
    logic       Busy;
    logic       Fault;
    logic       Overflow;
    logic [2:0] o_dbg_state;

    change_dispenser dut (
        .CLK         (CLK),
        .RST         (RST),
        .DROP50      (DROP50),
        .DROP100     (DROP100),
        .DROP500     (DROP500),
        .DROP1000    (DROP1000),
        .Sense       (Sense),
        .ClearFault  (ClearFault),
        .Motor       (Motor),
        .CoinOut     (CoinOut),
        .CoinDone    (CoinDone),
        .Busy        (Busy),
        .Fault       (Fault),
        .Overflow    (Overflow),
        .o_dbg_state (o_dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         errors = 0;
    int         checks = 0;
    int         cyc_no = 0;
    int         last_hi = -1000;
    int         hi_len = 0;
    int         strobes = 0;
    int         dones = 0;
    int         base_s;
    int         base_d;
    bit         auto_sense = 1'b0;
    bit         sense_given = 1'b1;
    logic [3:0] prev_motor = 4'b0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, model the coin
    // sensor, then sample and log outputs at the falling edge.
    task automatic tick(input logic [3:0] drops = 4'b0, input bit rst = 1'b0,
                        input bit clr = 1'b0, input bit sense = 1'b0);
        @(posedge CLK);
        #1;
        cyc_no++;
        {DROP1000, DROP500, DROP100, DROP50} = drops;
        RST        = rst;
        ClearFault = clr;
        Sense      = sense;
        if (auto_sense && !sense_given && (cyc_no >= last_hi + 3)) begin
            Sense       = 1'b1;
            sense_given = 1'b1;
        end
        @(negedge CLK);
        if (RST) begin
            prev_motor = 4'b0;
            hi_len     = 0;
        end else begin
            if (Motor != 4'b0) begin
                check("motor_onehot", 32'($countones(Motor)), 32'd1);
                if (prev_motor == 4'b0) begin
                    strobes++;
                    hi_len      = 0;
                    sense_given = 1'b0;
                end
                hi_len++;
                last_hi = cyc_no;
            end else if (prev_motor != 4'b0) begin
                check("strobe_len", hi_len, 32'd4);
            end
            prev_motor = Motor;
            if (CoinDone === 1'b1) begin
                dones++;
                if (exp_q.size() == 0) begin
                    check("coin_unexpected", CoinDone, 1'b0);
                end else begin
                    exp_code = exp_q.pop_front();
                    check("coin_code", CoinOut, exp_code);
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1; ClearFault = 1'b0; Sense = 1'b0;
        {DROP1000, DROP500, DROP100, DROP50} = 4'b0;

        // Reset state
        tick(.rst(1'b1));
        tick(.rst(1'b1));
        tick();
        check("rst_motor", Motor, 4'b0);
        check("rst_coindone", CoinDone, 1'b0);
        check("rst_coinout", CoinOut, 2'd0);
        check("rst_busy", Busy, 1'b0);
        check("rst_fault", Fault, 1'b0);
        check("rst_overflow", Overflow, 1'b0);
        check("rst_state", o_dbg_state, ST_IDLE);

        // Single 500 coin: latency, strobe, confirm, gap, idle
        auto_sense = 1'b1;
        base_s = strobes; base_d = dones;
        exp_q.push_back(COIN_500);
        tick(4'b0100);
        check("a_busy_n", Busy, 1'b0);
        tick();
        check("a_busy_n1", Busy, 1'b1);
        check("a_motor_n1", Motor, 4'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("a_motor_fire", Motor, 4'b0100);
        end
        tick();
        check("a_motor_wait", Motor, 4'b0);
        check("a_state_wait", o_dbg_state, ST_WAIT);
        tick();
        tick();
        check("a_coindone", CoinDone, 1'b1);
        check("a_coinout", CoinOut, COIN_500);
        tick();
        check("a_done_pulse", CoinDone, 1'b0);
        check("a_coinout_hold", CoinOut, COIN_500);
        check("a_state_gap", o_dbg_state, ST_GAP);
        tick();
        check("a_busy_gap", Busy, 1'b1);
        tick();
        check("a_busy_end", Busy, 1'b0);
        check("a_state_idle", o_dbg_state, ST_IDLE);
        check("a_strobes", strobes - base_s, 32'd1);
        check("a_dones", dones - base_d, 32'd1);

        // 50 and 1000 together: 1000 first, gap, then 50
        base_s = strobes; base_d = dones;
        exp_q.push_back(COIN_1000);
        exp_q.push_back(COIN_50);
        tick(4'b1001);
        tick();
        repeat (4) tick();
        check("b_motor_1000", Motor, 4'b1000);
        repeat (3) tick();
        check("b_done1", CoinDone, 1'b1);
        tick();
        tick();
        check("b_gap2", o_dbg_state, ST_GAP);
        check("b_gap_motor", Motor, 4'b0);
        tick();
        check("b_idle_rearb", o_dbg_state, ST_IDLE);
        check("b_busy_pending", Busy, 1'b1);
        tick();
        check("b_motor_50", Motor, 4'b0001);
        repeat (9) tick();
        check("b_busy_end", Busy, 1'b0);
        check("b_strobes", strobes - base_s, 32'd2);
        check("b_dones", dones - base_d, 32'd2);

        // 17 back-to-back 100 requests: saturation at 15
        auto_sense = 1'b0;
        base_s = strobes; base_d = dones;
        for (int i = 0; i < 15; i++) exp_q.push_back(COIN_100);
        for (int i = 0; i < 17; i++) begin
            tick(4'b0010);
            if (i == 15) check("c_ovf_not_yet", Overflow, 1'b0);
            if (i == 16) check("c_ovf_set", Overflow, 1'b1);
        end
        auto_sense = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (Busy == 1'b0) break;
        end
        check("c_drain_busy", Busy, 1'b0);
        check("c_strobes", strobes - base_s, 32'd15);
        check("c_dones", dones - base_d, 32'd15);
        check("c_ovf_sticky", Overflow, 1'b1);
        tick(.clr(1'b1));
        tick();
        check("c_ovf_cleared", Overflow, 1'b0);
        check("c_state", o_dbg_state, ST_IDLE);

        // Sensor never answers: timeout to FAULT
        auto_sense = 1'b0;
        base_s = strobes; base_d = dones;
        tick(4'b0010);
        repeat (5) tick();
        check("d_motor", Motor, 4'b0010);
        repeat (255) tick();
        check("d_fault_early", Fault, 1'b0);
        check("d_state_wait", o_dbg_state, ST_WAIT);
        tick();
        check("d_fault", Fault, 1'b1);
        check("d_state_fault", o_dbg_state, ST_FAULT);
        check("d_motor_off", Motor, 4'b0);
        tick(.sense(1'b1));
        check("d_sense_ignored", CoinDone, 1'b0);
        check("d_fault_hold", Fault, 1'b1);
        check("d_busy_fault", Busy, 1'b1);
        tick(.clr(1'b1));
        tick();
        check("d_clr_fault", Fault, 1'b0);
        check("d_clr_state", o_dbg_state, ST_IDLE);
        check("d_clr_busy", Busy, 1'b0);
        check("d_strobes", strobes - base_s, 32'd1);
        check("d_dones", dones - base_d, 32'd0);
        sense_given = 1'b1;

        // Repeat 1000 request arrives with the first coin's Sense
        auto_sense = 1'b1;
        base_s = strobes; base_d = dones;
        exp_q.push_back(COIN_1000);
        exp_q.push_back(COIN_1000);
        tick(4'b1000);
        repeat (7) tick();
        tick(4'b1000);
        check("e_done1", CoinDone, 1'b1);
        repeat (3) tick();
        check("e_idle_busy", Busy, 1'b1);
        check("e_idle_state", o_dbg_state, ST_IDLE);
        tick();
        check("e_motor2", Motor, 4'b1000);
        repeat (9) tick();
        check("e_busy_end", Busy, 1'b0);
        check("e_strobes", strobes - base_s, 32'd2);
        check("e_dones", dones - base_d, 32'd2);

        // Reset in the second FIRE cycle discards the coin
        base_s = strobes; base_d = dones;
        tick(4'b0100);
        tick();
        tick();
        check("f_fire1", Motor, 4'b0100);
        tick(.rst(1'b1));
        check("f_fire2", Motor, 4'b0100);
        tick();
        check("f_motor_off", Motor, 4'b0);
        check("f_busy", Busy, 1'b0);
        check("f_coindone", CoinDone, 1'b0);
        check("f_state", o_dbg_state, ST_IDLE);
        repeat (20) tick();
        check("f_no_done", dones - base_d, 32'd0);
        check("f_still_idle", Busy, 1'b0);

        // Reset wins over simultaneous requests
        tick(4'b1111, 1'b1);
        tick();
        check("g_rst_prio_busy", Busy, 1'b0);
        tick();
        check("g_rst_prio_motor", Motor, 4'b0);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4, cycles a hopper motor strobe stays high per coin.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for coin-sense after a strobe.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles between consecutive coins.
REQ-004 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports DROP50, DROP100, DROP500, DROP1000  input  1 each  one-cycle change-request pulses from the vending control unit.
REQ-007 SHALL have port Sense  input  1  coin-passed sensor shared by all hoppers, already synchronised.
REQ-008 SHALL have port ClearFault  input  1  operator fault acknowledge.
REQ-009 SHALL have port Motor  output  4  hopper strobes, bit0=50, bit1=100, bit2=500, bit3=1000; at most one bit high.
REQ-010 SHALL have port CoinOut  output  2  denomination code of last dispensed coin (0=50, 1=100, 2=500, 3=1000).
REQ-011 SHALL have port CoinDone  output  1  one-cycle pulse per confirmed coin, CoinOut valid the same cycle.
REQ-012 SHALL have ports Busy, Fault, Overflow  output  1 each  work pending or in progress / hopper timeout latched / request dropped at saturation (sticky).

Function
REQ-013 SHALL keep one 4-bit pending counter per denomination; a DROP pulse increments its counter.
REQ-014 SHALL saturate each counter at 15; a DROP at 15 leaves the counter at 15 and sets Overflow until RST or ClearFault.
REQ-015 SHALL accept DROP pulses in every state, including FAULT, and SHALL accept simultaneous pulses on several denominations in one cycle.
REQ-016 SHALL handle a DROP and a confirmed coin of the same denomination in the same cycle as a net-zero change to that counter.
REQ-017 SHALL implement FSM states IDLE, FIRE, WAIT, GAP, FAULT.
REQ-018 In IDLE with any counter nonzero, SHALL latch the highest-priority denomination (1000 > 500 > 100 > 50) into a select register and go to FIRE next cycle.
REQ-019 In IDLE with all counters zero, SHALL remain in IDLE.
REQ-020 In FIRE, SHALL drive Motor[sel]=1 for exactly PULSE_CYCLES cycles, then go to WAIT.
REQ-021 In WAIT, SHALL hold Motor=0 and count cycles.
REQ-022 In WAIT, Sense=1 SHALL, in that cycle, pulse CoinDone, set CoinOut=sel, decrement counter[sel], and go to GAP.
REQ-023 In WAIT, TIMEOUT_CYCLES cycles without Sense SHALL go to FAULT and set Fault; the counter for sel SHALL be left unchanged.
REQ-024 Sense SHALL be ignored in IDLE, FIRE, GAP and FAULT.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE, where arbitration is re-evaluated.
REQ-026 In FAULT, SHALL hold Motor=0 and keep Fault=1 until ClearFault=1.
REQ-027 ClearFault in FAULT SHALL zero all counters, clear Fault and Overflow, and go to IDLE; ClearFault in other states SHALL clear only Overflow.
REQ-028 Busy SHALL be 1 when state is not IDLE or any counter is nonzero.
REQ-029 Latency SHALL be as follows: a DROP pulse in cycle n, in IDLE with no other work, gives Motor high from cycle n+2 through n+1+PULSE_CYCLES.

Reset
REQ-030 RST SHALL have priority over all inputs, including a simultaneous DROP or Sense.
REQ-031 RST SHALL force state IDLE, all counters 0, all timers 0, Motor=0, CoinDone=0, CoinOut=0, Busy=0, Fault=0, Overflow=0.
REQ-032 RST asserted mid-FIRE SHALL drop Motor to 0 in the next cycle and discard the pending coin.

Structure
REQ-033 SHALL place the denomination codes, the one-hot Motor bit mapping, and the FSM state encodings in the shared vending package used by the control unit.
REQ-034 SHALL use one sub-module, coin_counter: a 4-bit saturating up/down counter with inc, dec and clr inputs and a sat flag, instantiated four times.

Verification
REQ-035 Bench SHALL drive DROP500 for 1 cycle with Sense returned 3 cycles after each strobe -> one 4-cycle Motor[2] strobe, CoinDone with CoinOut=2, Busy back to 0.
REQ-036 Bench SHALL drive DROP50 and DROP1000 in the same cycle -> Motor[3] strobe first, 2-cycle gap, then Motor[0] strobe; two CoinDone pulses in order 3, 0.
REQ-037 Bench SHALL drive DROP100 17 times back-to-back -> counter holds 15, Overflow=1, exactly 15 Motor[1] strobes.
REQ-038 Bench SHALL drive DROP100 and never assert Sense -> Fault=1 at 255 cycles after the strobe ends, Motor stays 0; ClearFault -> IDLE, Busy=0.
REQ-039 Bench SHALL drive DROP1000, then DROP1000 again in the same cycle as the coin-1 Sense -> counter stays 1, a second strobe follows the gap.
REQ-040 Bench SHALL assert RST during the second FIRE cycle -> Motor=0 and Busy=0 in the next cycle, with no CoinDone.
